pwm_measure: RTL and testbench

//  Receive-side counterpart of the photonic-switch PWM generator: samples an incoming PWM

---
 rtl/pwm_measure_pkg.sv | 19 +
 rtl/sync_edge_detect.sv | 30 +++
 rtl/pwm_measure.sv | 180 ++++++++++++++++++
 tb/tb_pwm_measure.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_measure_pkg.sv
// Shared types and helpers for the PWM period measurement block.
package pwm_measure_pkg;

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STUCK = 2'd3
    } state_t;

    localparam int DEF_W           = 7;
    localparam int DEF_TIMEOUT_CYC = 255;

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
        return (v >= lim) ? lim : v + 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous line, plus one extra flop for edge detection.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_s,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync   <= '0;
            r_s_prev <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_s_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_s    = r_sync[SYNC_STAGES-1];
    assign o_rise = o_s & ~r_s_prev;
    assign o_fall = ~o_s & r_s_prev;

endmodule

// File: rtl/pwm_measure.sv
// Measures high/low phase lengths of each PWM period on the core clock and flags a stuck line.
// Handshake: valid is a single-cycle strobe with no ready; high_cnt/low_cnt/ovf hold until the next strobe.
module pwm_measure
    import pwm_measure_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic         clkCore,
    input  logic         reset_n,
    input  logic         signal,
    output logic [W-1:0] high_cnt,
    output logic [W-1:0] low_cnt,
    output logic         valid,
    output logic         ovf,
    output logic         stuck,
    output logic         stuck_level,
    output state_t       o_dbg_state
);

    localparam int            IW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0]  CNT_MAX  = '1;
    localparam logic [IW-1:0] IDLE_MAX = '1;
    localparam logic [IW-1:0] IDLE_LIM = IW'(TIMEOUT_CYC);

    logic          w_s;
    logic          w_rise;
    logic          w_fall;
    logic          w_edge;
    logic [IW-1:0] w_idle_nxt;
    logic          w_timeout;
    logic [W-1:0]  w_hcnt_inc;
    logic [W-1:0]  w_lcnt_inc;
    logic          w_publish;
    logic          w_start_high;
    logic          w_start_low;
    logic          w_go_stuck;
    logic          w_leave_stuck;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_idle;
    logic [W-1:0]  r_hcnt;
    logic [W-1:0]  r_lcnt;
    logic          r_sat;
    logic [W-1:0]  r_high_cnt;
    logic [W-1:0]  r_low_cnt;
    logic          r_valid;
    logic          r_ovf;
    logic          r_stuck;
    logic          r_stuck_level;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk   (clkCore),
        .i_rst_n (reset_n),
        .i_async (signal),
        .o_s     (w_s),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_edge     = w_rise | w_fall;
    assign w_idle_nxt = w_edge ? '0 : IW'(sat_inc(32'(r_idle), 32'(IDLE_MAX)));
    // An edge in the same cycle always beats the timeout.
    assign w_timeout  = ~w_edge && (w_idle_nxt == IDLE_LIM);
    assign w_hcnt_inc = W'(sat_inc(32'(r_hcnt), 32'(CNT_MAX)));
    assign w_lcnt_inc = W'(sat_inc(32'(r_lcnt), 32'(CNT_MAX)));

    always_ff @(posedge clkCore or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ACQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACQ: begin
                if (w_rise)         w_state_nxt = HIGH;
                else if (w_timeout) w_state_nxt = STUCK;
            end
            HIGH: begin
                if (w_fall)         w_state_nxt = LOW;
                else if (w_timeout) w_state_nxt = STUCK;
            end
            LOW: begin
                if (w_rise)         w_state_nxt = HIGH;
                else if (w_timeout) w_state_nxt = STUCK;
            end
            STUCK: begin
                if (w_rise)         w_state_nxt = HIGH;
                else if (w_fall)    w_state_nxt = ACQ;
            end
            default: w_state_nxt = ACQ;
        endcase
    end

    always_comb begin
        w_publish     = 1'b0;
        w_start_high  = 1'b0;
        w_start_low   = 1'b0;
        w_go_stuck    = 1'b0;
        w_leave_stuck = 1'b0;
        case (r_state)
            ACQ: begin
                w_start_high = w_rise;
                w_go_stuck   = w_timeout;
            end
            HIGH: begin
                w_start_low  = w_fall;
                w_go_stuck   = w_timeout;
            end
            LOW: begin
                w_publish    = w_rise;
                w_start_high = w_rise;
                w_go_stuck   = w_timeout;
            end
            STUCK: begin
                w_start_high  = w_rise;
                w_leave_stuck = w_edge;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clkCore or negedge reset_n) begin
        if (!reset_n) begin
            r_idle        <= '0;
            r_hcnt        <= '0;
            r_lcnt        <= '0;
            r_sat         <= 1'b0;
            r_high_cnt    <= '0;
            r_low_cnt     <= '0;
            r_valid       <= 1'b0;
            r_ovf         <= 1'b0;
            r_stuck       <= 1'b0;
            r_stuck_level <= 1'b0;
        end else begin
            r_idle  <= w_idle_nxt;
            r_valid <= w_publish;
            if (w_publish) begin
                r_high_cnt <= r_hcnt;
                r_low_cnt  <= r_lcnt;
                r_ovf      <= r_sat;
            end
            // The edge cycle is already cycle 1 of the new phase.
            if (w_start_high) begin
                r_hcnt <= W'(1);
                r_lcnt <= '0;
                r_sat  <= 1'b0;
            end else if (w_start_low) begin
                r_lcnt <= W'(1);
            end else if (r_state == HIGH) begin
                r_hcnt <= w_hcnt_inc;
                if (r_hcnt == CNT_MAX) r_sat <= 1'b1;
            end else if (r_state == LOW) begin
                r_lcnt <= w_lcnt_inc;
                if (r_lcnt == CNT_MAX) r_sat <= 1'b1;
            end
            if (w_go_stuck) begin
                r_stuck       <= 1'b1;
                r_stuck_level <= w_s;
            end else if (w_leave_stuck) begin
                r_stuck <= 1'b0;
            end
        end
    end

    assign high_cnt    = r_high_cnt;
    assign low_cnt     = r_low_cnt;
    assign valid       = r_valid;
    assign ovf         = r_ovf;
    assign stuck       = r_stuck;
    assign stuck_level = r_stuck_level;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pwm_measure.sv
// Randomized and directed bench for pwm_measure against an event-time model of the measurement.
module tb_pwm_measure;
    import pwm_measure_pkg::*;

    localparam int W    = 7;
    localparam int S    = 2;
    localparam int TO   = 255;
    localparam int CMAX = (1 << W) - 1;

    logic         clkCore = 1'b0;
    logic         reset_n = 1'b0;
    logic         signal  = 1'b0;
    logic [W-1:0] high_cnt;
    logic [W-1:0] low_cnt;
    logic         valid;
    logic         ovf;
    logic         stuck;
    logic         stuck_level;
    state_t       dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_valid11 = 0;

    pwm_measure #(.W(W), .SYNC_STAGES(S), .TIMEOUT_CYC(TO)) dut (
        .clkCore     (clkCore),
        .reset_n     (reset_n),
        .signal      (signal),
        .high_cnt    (high_cnt),
        .low_cnt     (low_cnt),
        .valid       (valid),
        .ovf         (ovf),
        .stuck       (stuck),
        .stuck_level (stuck_level),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clkCore = ~clkCore;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on the synchronized line in terms of event cycles: a period is
    // rise time -> fall time -> next rise time, lengths are time differences.
    logic xh[0:S];
    int   m_n, m_rc, m_fc, m_te;
    logic m_stuck;
    logic m_cur, m_prv;
    int   m_hl, m_ll;
    logic         e_valid, e_ovf, e_stuck, e_stuck_level;
    logic [W-1:0] e_high, e_low;

    always @(posedge clkCore or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= S; i++) xh[i] = 1'b0;
            m_n = 0; m_rc = -1; m_fc = -1; m_te = -1; m_stuck = 1'b0;
            e_valid = 0; e_ovf = 0; e_stuck = 0; e_stuck_level = 0;
            e_high = '0; e_low = '0;
        end else begin
            m_cur = xh[S-1];
            m_prv = xh[S];
            e_valid = 1'b0;
            if (m_cur && !m_prv) begin
                if (!m_stuck && m_rc >= 0 && m_fc >= 0) begin
                    m_hl = m_fc - m_rc;
                    m_ll = m_n - m_fc;
                    e_high  = W'((m_hl > CMAX) ? CMAX : m_hl);
                    e_low   = W'((m_ll > CMAX) ? CMAX : m_ll);
                    e_ovf   = (m_hl > CMAX) || (m_ll > CMAX);
                    e_valid = 1'b1;
                end
                m_rc = m_n; m_fc = -1; m_stuck = 1'b0; m_te = m_n;
            end else if (!m_cur && m_prv) begin
                if (m_stuck) begin
                    m_stuck = 1'b0; m_rc = -1;
                end else if (m_rc >= 0) begin
                    m_fc = m_n;
                end
                m_te = m_n;
            end else if (!m_stuck && (m_n - m_te) == TO) begin
                m_stuck = 1'b1; e_stuck_level = m_cur; m_rc = -1; m_fc = -1;
            end
            e_stuck = m_stuck;
            for (int i = S; i > 0; i--) xh[i] = xh[i-1];
            xh[0] = signal;
            m_n++;
        end
    end

    // ---------------- compare ----------------
    always @(negedge clkCore) begin
        if (reset_n) begin
            chk("valid", 32'(valid), 32'(e_valid));
            chk("high_cnt", 32'(high_cnt), 32'(e_high));
            chk("low_cnt", 32'(low_cnt), 32'(e_low));
            chk("ovf", 32'(ovf), 32'(e_ovf));
            chk("stuck", 32'(stuck), 32'(e_stuck));
            if (e_stuck) chk("stuck_level", 32'(stuck_level), 32'(e_stuck_level));
            if (valid) n_valid++;
            if (valid && high_cnt == W'(1) && low_cnt == W'(1)) n_valid11++;
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic lvl, input int n);
        signal = lvl;
        repeat (n) @(negedge clkCore);
    endtask

    task automatic periods(input int h, input int l, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            drive(1'b1, h);
            drive(1'b0, l);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_high"}, 32'(high_cnt), 0);
        chk({tag, "_low"}, 32'(low_cnt), 0);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_ovf"}, 32'(ovf), 0);
        chk({tag, "_stuck"}, 32'(stuck), 0);
        chk({tag, "_stuck_level"}, 32'(stuck_level), 0);
    endtask

    // ---------------- stimulus ----------------
    int v0;
    int len;
    int r;

    initial begin
        repeat (3) @(negedge clkCore);
        #1;
        chk_all_zero("reset");
        @(negedge clkCore);
        reset_n = 1'b1;
        drive(1'b0, 4);

        // 3 high / 5 low
        v0 = n_valid;
        periods(3, 5, 6);
        chk("p35_count", 32'(n_valid - v0), 5);
        chk("p35_high", 32'(high_cnt), 3);
        chk("p35_low", 32'(low_cnt), 5);
        chk("p35_ovf", 32'(ovf), 0);

        // saturating high phase
        drive(1'b1, 200); drive(1'b0, 10); drive(1'b1, 200);
        chk("sat_high", 32'(high_cnt), 127);
        chk("sat_low", 32'(low_cnt), 10);
        chk("sat_ovf", 32'(ovf), 1);
        drive(1'b0, 10);
        periods(3, 5, 2);
        chk("unsat_high", 32'(high_cnt), 3);
        chk("unsat_ovf", 32'(ovf), 0);

        // stuck low
        drive(1'b0, 300);
        chk("stuck_lo", 32'(stuck), 1);
        chk("stuck_lo_level", 32'(stuck_level), 0);
        chk("stuck_lo_high", 32'(high_cnt), 3);
        chk("stuck_lo_low", 32'(low_cnt), 5);
        v0 = n_valid;
        periods(3, 5, 3);
        chk("after_stuck_lo_count", 32'(n_valid - v0), 2);

        // stuck high
        drive(1'b1, 300);
        chk("stuck_hi", 32'(stuck), 1);
        chk("stuck_hi_level", 32'(stuck_level), 1);
        v0 = n_valid;
        drive(1'b0, 5);
        chk("stuck_hi_exit", 32'(stuck), 0);
        periods(3, 5, 2);
        chk("after_stuck_hi_count", 32'(n_valid - v0), 1);

        // reset in mid-HIGH phase
        drive(1'b1, 20);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("midreset");
        @(negedge clkCore);
        reset_n = 1'b1;
        v0 = n_valid;
        drive(1'b1, 10); drive(1'b0, 5);
        periods(3, 5, 2);
        chk("midreset_count", 32'(n_valid - v0), 2);

        // 1/1 toggle
        v0 = n_valid11;
        periods(1, 1, 20);
        drive(1'b0, 10);
        chk("toggle_count", 32'(n_valid11 - v0), 19);

        // random phases, occasionally saturating or timing out
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       len = $urandom_range(120, 140);
            else if (r < 11) len = $urandom_range(256, 270);
            else             len = $urandom_range(1, 9);
            drive(logic'(i % 2 == 0), len);
        end
        drive(1'b0, 20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
